// File: rtl/complex_mult_pkg.sv
// +-----------------------------------------------------------------------------+
// | complex_mult_pkg: shared operand-entry layout for the complex multiplier.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package complex_mult_pkg;

  typedef enum logic [1:0] {
    FLD_OP1_RE = 2'd0,
    FLD_OP1_IM = 2'd1,
    FLD_OP2_RE = 2'd2,
    FLD_OP2_IM = 2'd3
  } field_e;

  localparam int DATA_W_DEF = 8;
  localparam int ENTRY_W    = 4 * DATA_W_DEF;
  localparam int OP1_RE_LSB = 0;
  localparam int OP1_IM_LSB = DATA_W_DEF;
  localparam int OP2_RE_LSB = 2 * DATA_W_DEF;
  localparam int OP2_IM_LSB = 3 * DATA_W_DEF;

  // Field offset for an arbitrary component width; matches the constants above.
  function automatic int field_lsb(input int data_w, input field_e fld);
    return data_w * int'(fld);
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_op_fifo_ptr_ctrl.sv
// +-----------------------------------------------------------------------------+
// | fifo_ptr_ctrl: read/write pointers, occupancy count and handshake qualify. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fifo_ptr_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clr,
  input  logic              i_push_req,
  input  logic              i_pop_req,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_push,
  output logic              o_pop,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [ADDR_W-1:0] o_rd_ptr,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // Full/empty come from the registered count only, so a pop never frees a slot in the same cycle.
  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push_req & ~o_full;
  assign w_pop   = i_pop_req & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rstn || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_push   = w_push;
  assign o_pop    = w_pop;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule

`default_nettype wire

// File: rtl/complex_op_fifo.sv
// +-----------------------------------------------------------------------------+
// | complex_op_fifo: DEPTH-entry operand-pair buffer ahead of the multiplier.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module complex_op_fifo
  import complex_mult_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sw_rst,
  input  logic              in_val,
  input  logic [DATA_W-1:0] in_op1_re,
  input  logic [DATA_W-1:0] in_op1_im,
  input  logic [DATA_W-1:0] in_op2_re,
  input  logic [DATA_W-1:0] in_op2_im,
  output logic              in_ready,
  output logic              op_val,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op1_re,
  output logic [DATA_W-1:0] op1_im,
  output logic [DATA_W-1:0] op2_re,
  output logic [DATA_W-1:0] op2_im,
  output logic [ADDR_W:0]   fill_level
);

  localparam int c_ENTRY_W    = 4 * DATA_W;
  localparam int c_OP1_RE_LSB = field_lsb(DATA_W, FLD_OP1_RE);
  localparam int c_OP1_IM_LSB = field_lsb(DATA_W, FLD_OP1_IM);
  localparam int c_OP2_RE_LSB = field_lsb(DATA_W, FLD_OP2_RE);
  localparam int c_OP2_IM_LSB = field_lsb(DATA_W, FLD_OP2_IM);

  logic [c_ENTRY_W-1:0] r_mem [0:DEPTH-1];
  logic [c_ENTRY_W-1:0] w_wr_entry;
  logic [c_ENTRY_W-1:0] w_rd_entry;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [ADDR_W-1:0]    w_wr_ptr;
  logic [ADDR_W-1:0]    w_rd_ptr;
  logic [ADDR_W:0]      w_count;

  fifo_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rstn       (rstn),
    .i_clr      (sw_rst),
    .i_push_req (in_val),
    .i_pop_req  (op_ready),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_push     (w_push),
    .o_pop      (w_pop),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (w_count)
  );

  always_comb begin
    w_wr_entry = '0;
    w_wr_entry[c_OP1_RE_LSB +: DATA_W] = in_op1_re;
    w_wr_entry[c_OP1_IM_LSB +: DATA_W] = in_op1_im;
    w_wr_entry[c_OP2_RE_LSB +: DATA_W] = in_op2_re;
    w_wr_entry[c_OP2_IM_LSB +: DATA_W] = in_op2_im;
  end

  // Storage is cleared on reset so the head output reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!rstn || sw_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= w_wr_entry;
    end
  end

  assign w_rd_entry = r_mem[w_rd_ptr];

  assign in_ready   = ~w_full;
  assign op_val     = ~w_empty;
  assign op1_re     = w_rd_entry[c_OP1_RE_LSB +: DATA_W];
  assign op1_im     = w_rd_entry[c_OP1_IM_LSB +: DATA_W];
  assign op2_re     = w_rd_entry[c_OP2_RE_LSB +: DATA_W];
  assign op2_im     = w_rd_entry[c_OP2_IM_LSB +: DATA_W];
  assign fill_level = w_count;

endmodule

`default_nettype wire

// File: tb/tb_complex_op_fifo.sv
// +-----------------------------------------------------------------------------+
// | tb_complex_op_fifo: table vectors plus a push-order scoreboard.            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_complex_op_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        swr;
    logic [31:0] d;
    logic [2:0]  fill;
    logic        ir;
    logic        ov;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sw_rst;
  logic          in_val;
  logic [DW-1:0] in_op1_re, in_op1_im, in_op2_re, in_op2_im;
  logic          in_ready;
  logic          op_val;
  logic          op_ready;
  logic [DW-1:0] op1_re, op1_im, op2_re, op2_im;
  logic [AW:0]   fill_level;

  int          errors = 0;
  int          checks = 0;
  int          pops   = 0;
  bit          mon_en = 1'b0;
  logic [31:0] q[$];
  logic [31:0] dummy;
  vec_t        tbl[15];

  always #5 clk = ~clk;

  complex_op_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sw_rst     (sw_rst),
    .in_val     (in_val),
    .in_op1_re  (in_op1_re),
    .in_op1_im  (in_op1_im),
    .in_op2_re  (in_op2_re),
    .in_op2_im  (in_op2_im),
    .in_ready   (in_ready),
    .op_val     (op_val),
    .op_ready   (op_ready),
    .op1_re     (op1_re),
    .op1_im     (op1_im),
    .op2_re     (op2_re),
    .op2_im     (op2_im),
    .fill_level (fill_level)
  );

  function automatic logic [31:0] pr(input int k);
    return {8'(k + 30), 8'(k + 20), 8'(k + 10), 8'(k)};
  endfunction

  function automatic vec_t mk(input logic iv, input logic ordy, input logic swr,
                              input logic [31:0] d, input int fill, input logic ir,
                              input logic ov);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.swr = swr; v.d = d;
    v.fill = 3'(fill); v.ir = ir; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic swr, input logic [31:0] d);
    in_val   = iv;
    op_ready = ordy;
    sw_rst   = swr;
    {in_op2_im, in_op2_re, in_op1_im, in_op1_re} = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: levels are checked against the queue, popped heads against push order.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_fill", 32'(fill_level), 32'(q.size()));
      chk("mon_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("mon_op_val", 32'(op_val), 32'(q.size() != 0));
      if (!rstn || sw_rst) begin
        q.delete();
      end else begin
        if (op_val && op_ready) begin
          if (q.size() > 0) begin
            chk("mon_head_data", {op2_im, op2_re, op1_im, op1_re}, q[0]);
            dummy = q.pop_front();
          end
          pops++;
        end
        if (in_val && in_ready) q.push_back({in_op2_im, in_op2_re, in_op1_im, in_op1_re});
      end
    end
  end

  initial begin
    int   sent;
    int   pops0;
    logic iv;
    logic acc;

    tbl[0]  = mk(1, 1, 0, 32'h06050403, 1, 1, 1);
    tbl[1]  = mk(0, 1, 0, 32'h0,        0, 1, 0);
    tbl[2]  = mk(1, 0, 0, pr(1),        1, 1, 1);
    tbl[3]  = mk(1, 0, 0, pr(2),        2, 1, 1);
    tbl[4]  = mk(1, 0, 0, pr(3),        3, 1, 1);
    tbl[5]  = mk(1, 0, 0, pr(4),        4, 0, 1);
    tbl[6]  = mk(1, 0, 0, pr(5),        4, 0, 1);
    tbl[7]  = mk(1, 1, 0, pr(5),        3, 1, 1);
    tbl[8]  = mk(1, 0, 0, pr(5),        4, 0, 1);
    tbl[9]  = mk(0, 1, 0, 32'h0,        3, 1, 1);
    tbl[10] = mk(0, 1, 0, 32'h0,        2, 1, 1);
    tbl[11] = mk(1, 1, 0, pr(6),        2, 1, 1);
    tbl[12] = mk(1, 0, 0, pr(7),        3, 1, 1);
    tbl[13] = mk(1, 0, 1, pr(8),        0, 1, 0);
    tbl[14] = mk(0, 1, 0, 32'h0,        0, 1, 0);

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_op_val", 32'(op_val), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_op_data", {op2_im, op2_re, op1_im, op1_re}, 32'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].swr, tbl[i].d);
      tick();
      chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(tbl[i].fill));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("vec%0d_op_val", i), 32'(op_val), 32'(tbl[i].ov));
    end

    // Random handshakes: ten pairs through a 4-deep FIFO wrap the pointers twice.
    sent  = 0;
    pops0 = pops;
    for (int cyc = 0; cyc < 400 && (pops - pops0) < 10; cyc++) begin
      iv = (sent < 10) && ($urandom_range(0, 1) == 1);
      drive(iv, 1'($urandom_range(0, 1)), 1'b0, pr(100 + sent));
      acc = iv && in_ready;
      tick();
      if (acc) sent++;
    end
    chk("wrap_pops", 32'(pops - pops0), 32'd10);
    chk("wrap_fill", 32'(fill_level), 32'd0);

    // Hard reset mid-stream with a coincident push.
    drive(1'b1, 1'b0, 1'b0, pr(50));
    tick();
    drive(1'b1, 1'b0, 1'b0, pr(51));
    tick();
    chk("pre_rst_fill", 32'(fill_level), 32'd2);
    rstn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, pr(52));
    tick();
    rstn = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    chk("mid_rst_op_val", 32'(op_val), 32'd0);
    chk("mid_rst_op_data", {op2_im, op2_re, op1_im, op1_re}, 32'd0);
    tick();
    chk("post_rst_fill", 32'(fill_level), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
